// File: rtl/i2c_ld_access_sched.sv
// Shares the laser-driver I2C command path between JTAG and a periodic DAQ/TRG readback refresher
// that keeps an XOR signature per device. Define I2C_SCHED_WDOG_EN to enable the parser watchdog.
module i2c_ld_access_sched #(
  parameter int          PER_W   = 16,
  parameter int          N_RD    = 7,
  parameter logic [7:0]  DAQ_CMD = 8'h7A,
  parameter logic [7:0]  TRG_CMD = 8'h7C,
  parameter logic [23:0] TMO_CYC = 24'd400000
) (
  input  logic             CLK40,
  input  logic             rst_fifo,
  input  logic             TICK,
  input  logic             REFRESH_ENA,
  input  logic [PER_W-1:0] REFRESH_PERIOD,
  input  logic             JTAG_REQ,
  input  logic [7:0]       JTAG_WDATA,
  input  logic             JTAG_WE,
  input  logic             JTAG_START,
  input  logic             JTAG_RDENA,
  input  logic             PRS_DONE,
  input  logic             RBK_EMPTY,
  input  logic [7:0]       RBK_DATA,
  output logic             JTAG_GNT,
  output logic [7:0]       WFF_DATA,
  output logic             WFF_WE,
  output logic             PRS_START,
  output logic             RBK_RDENA,
  output logic             PRS_RESET,
  output logic [7:0]       DAQ_SIG,
  output logic [7:0]       TRG_SIG,
  output logic             SIG_VLD,
  output logic             SIG_CHG,
  output logic             TMO_ERR,
  output logic             BUSY
);
  localparam int            CW     = $clog2(N_RD + 1);
  localparam logic [CW-1:0] N_RD_C = CW'(N_RD);

  typedef enum logic [3:0] {
    S_IDLE, S_JTAG, S_R_CMD, S_R_ADDR, S_R_START, S_R_WAIT, S_R_DRAIN, S_R_NEXT, S_R_REC
  } state_t;

  state_t           state_q;
  logic             dev_q;
  logic [PER_W-1:0] tick_cnt_q;
  logic             pend_q;
  logic [CW-1:0]    iss_q;
  logic [CW-1:0]    acc_cnt_q;
  logic             rd_q;
  logic [7:0]       acc_q;
  logic [7:0]       daq_sig_q;
  logic [7:0]       trg_sig_q;
  logic             sig_vld_q;
  logic             sig_chg_q;
  logic             tmo_err_q;

  logic tick_run, tick_wrap, ref_take, drain_rd, acc_last, tmo_hit;

  assign tick_run  = REFRESH_ENA && (REFRESH_PERIOD != '0);
  assign tick_wrap = tick_run && TICK && (tick_cnt_q == REFRESH_PERIOD - PER_W'(1));
  assign ref_take  = (state_q == S_IDLE) && !JTAG_REQ && pend_q;
  assign drain_rd  = (state_q == S_R_DRAIN) && !RBK_EMPTY && (iss_q < N_RD_C);
  assign acc_last  = rd_q && (acc_cnt_q == N_RD_C - CW'(1));

  // A period that elapses while a refresh runs stays queued; a new wrap wins over the take.
  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) begin
      tick_cnt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (!tick_run)
        tick_cnt_q <= '0;
      else if (TICK)
        tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + PER_W'(1);
      if (tick_wrap)
        pend_q <= 1'b1;
      else if (ref_take)
        pend_q <= 1'b0;
    end
  end

`ifdef I2C_SCHED_WDOG_EN
  logic [23:0] wdog_q;
  logic        wdog_run;

  assign wdog_run = ((state_q == S_R_WAIT) && !PRS_DONE) || (state_q == S_R_DRAIN);
  assign tmo_hit  = ((state_q == S_R_WAIT) || (state_q == S_R_DRAIN)) &&
                    (wdog_q == TMO_CYC - 24'd1);

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo)
      wdog_q <= '0;
    else
      wdog_q <= wdog_run ? wdog_q + 24'd1 : '0;
  end
`else
  // No watchdog: the timeout can never fire, so R_REC is unreachable.
  assign tmo_hit = (TMO_CYC == 24'd0) & 1'b0;
`endif

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) begin
      state_q   <= S_IDLE;
      dev_q     <= 1'b0;
      iss_q     <= '0;
      acc_cnt_q <= '0;
      rd_q      <= 1'b0;
      acc_q     <= '0;
      daq_sig_q <= '0;
      trg_sig_q <= '0;
      sig_vld_q <= 1'b0;
      sig_chg_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      rd_q <= drain_rd;
      case (state_q)
        S_IDLE: begin
          if (JTAG_REQ)
            state_q <= S_JTAG;
          else if (pend_q) begin
            state_q <= S_R_CMD;
            dev_q   <= 1'b0;
          end
        end
        S_JTAG:    if (!JTAG_REQ) state_q <= S_IDLE;
        S_R_CMD:   state_q <= S_R_ADDR;
        S_R_ADDR:  state_q <= S_R_START;
        S_R_START: state_q <= S_R_WAIT;
        S_R_WAIT: begin
          if (PRS_DONE) begin
            state_q   <= S_R_DRAIN;
            iss_q     <= '0;
            acc_cnt_q <= '0;
            acc_q     <= '0;
          end else if (tmo_hit)
            state_q <= S_R_REC;
        end
        S_R_DRAIN: begin
          if (drain_rd)
            iss_q <= iss_q + CW'(1);
          // FIFO dout is valid the cycle after the read strobe.
          if (rd_q) begin
            acc_q     <= acc_q ^ RBK_DATA;
            acc_cnt_q <= acc_cnt_q + CW'(1);
          end
          if (acc_last)
            state_q <= S_R_NEXT;
          else if (tmo_hit)
            state_q <= S_R_REC;
        end
        S_R_NEXT: begin
          if (!dev_q) begin
            daq_sig_q <= acc_q;
            if (sig_vld_q && (acc_q != daq_sig_q)) sig_chg_q <= 1'b1;
            dev_q   <= 1'b1;
            state_q <= S_R_CMD;
          end else begin
            trg_sig_q <= acc_q;
            if (sig_vld_q && (acc_q != trg_sig_q)) sig_chg_q <= 1'b1;
            sig_vld_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_R_REC: begin
          tmo_err_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    WFF_DATA  = 8'h00;
    WFF_WE    = 1'b0;
    PRS_START = 1'b0;
    RBK_RDENA = 1'b0;
    case (state_q)
      S_JTAG: begin
        WFF_DATA  = JTAG_WDATA;
        WFF_WE    = JTAG_WE;
        PRS_START = JTAG_START;
        RBK_RDENA = JTAG_RDENA;
      end
      S_R_CMD: begin
        WFF_WE   = 1'b1;
        WFF_DATA = dev_q ? TRG_CMD : DAQ_CMD;
      end
      S_R_ADDR:  WFF_WE    = 1'b1;
      S_R_START: PRS_START = 1'b1;
      S_R_DRAIN: RBK_RDENA = drain_rd;
      default: ;
    endcase
  end

  assign JTAG_GNT  = (state_q == S_JTAG);
  assign BUSY      = (state_q != S_IDLE);
  assign PRS_RESET = (state_q == S_R_REC);
  assign TMO_ERR   = tmo_err_q;
  assign DAQ_SIG   = daq_sig_q;
  assign TRG_SIG   = trg_sig_q;
  assign SIG_VLD   = sig_vld_q;
  assign SIG_CHG   = sig_chg_q;

endmodule

// File: tb/tb_i2c_ld_access_sched.sv
// Directed bench for i2c_ld_access_sched with a behavioural parser/readback-FIFO responder.
module tb_i2c_ld_access_sched;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_fifo = 1'b1;
  logic        TICK = 1'b0, REFRESH_ENA = 1'b0;
  logic [15:0] REFRESH_PERIOD = 16'd0;
  logic        JTAG_REQ = 1'b0, JTAG_WE = 1'b0, JTAG_START = 1'b0, JTAG_RDENA = 1'b0;
  logic [7:0]  JTAG_WDATA = 8'h00;
  logic        PRS_DONE = 1'b0, RBK_EMPTY = 1'b1;
  logic [7:0]  RBK_DATA = 8'h00;
  logic        JTAG_GNT, WFF_WE, PRS_START, RBK_RDENA, PRS_RESET;
  logic [7:0]  WFF_DATA, DAQ_SIG, TRG_SIG;
  logic        SIG_VLD, SIG_CHG, TMO_ERR, BUSY;

  i2c_ld_access_sched #(.TMO_CYC(24'(TMO))) dut (
    .CLK40(clk), .rst_fifo(rst_fifo), .TICK(TICK), .REFRESH_ENA(REFRESH_ENA),
    .REFRESH_PERIOD(REFRESH_PERIOD), .JTAG_REQ(JTAG_REQ), .JTAG_WDATA(JTAG_WDATA),
    .JTAG_WE(JTAG_WE), .JTAG_START(JTAG_START), .JTAG_RDENA(JTAG_RDENA),
    .PRS_DONE(PRS_DONE), .RBK_EMPTY(RBK_EMPTY), .RBK_DATA(RBK_DATA),
    .JTAG_GNT(JTAG_GNT), .WFF_DATA(WFF_DATA), .WFF_WE(WFF_WE), .PRS_START(PRS_START),
    .RBK_RDENA(RBK_RDENA), .PRS_RESET(PRS_RESET), .DAQ_SIG(DAQ_SIG), .TRG_SIG(TRG_SIG),
    .SIG_VLD(SIG_VLD), .SIG_CHG(SIG_CHG), .TMO_ERR(TMO_ERR), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] wff_log[$];
  logic [7:0] rbk_q[$];
  logic [7:0] daq_b[7];
  logic [7:0] trg_b[7];
  int start_cnt = 0, rd_cnt = 0, rd_bad = 0, prs_rst_cnt = 0;
  int cyc = 0, start_cyc = 0, rst_cyc = 0, done_dly = 0, done_wait = 3;
  bit rd_pend = 0, start_pend = 0, auto_done = 1, tog = 0, phase = 0, dev = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else
      $display("ok   %s = %0h", tag, got);
  endtask

  // Scheduler-side activity only; JTAG pass-through is checked directly.
  always @(negedge clk) begin
    cyc++;
    rd_pend = 1'b0;
    if (!rst_fifo && !JTAG_GNT) begin
      if (WFF_WE) begin
        wff_log.push_back(WFF_DATA);
        if (WFF_DATA == 8'h7A) dev = 1'b0;
        else if (WFF_DATA == 8'h7C) dev = 1'b1;
      end
      if (PRS_START) begin start_cnt++; start_pend = 1'b1; start_cyc = cyc; end
      if (RBK_RDENA) begin rd_cnt++; rd_pend = 1'b1; if (RBK_EMPTY) rd_bad++; end
      if (PRS_RESET) begin prs_rst_cnt++; rst_cyc = cyc; end
    end
  end

  // Parser + readback FIFO responder; two junk bytes follow the 7 real ones.
  always @(posedge clk) begin
    #1;
    if (rst_fifo) begin
      rbk_q.delete();
      done_dly = 0;
      PRS_DONE = 1'b0;
      start_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rbk_q.size() > 0) RBK_DATA = rbk_q.pop_front();
        else RBK_DATA = 8'hEE;
      end
      PRS_DONE = 1'b0;
      if (start_pend) begin
        start_pend = 1'b0;
        if (auto_done) done_dly = done_wait;
      end
      if (done_dly > 0) begin
        done_dly--;
        if (done_dly == 0) begin
          PRS_DONE = 1'b1;
          rbk_q.delete();
          for (int i = 0; i < 7; i++) rbk_q.push_back(dev ? trg_b[i] : daq_b[i]);
          rbk_q.push_back(8'hFF);
          rbk_q.push_back(8'hFF);
        end
      end
    end
    phase = !phase;
    RBK_EMPTY = (rbk_q.size() == 0) || (tog && phase);
  end

  task automatic clr_logs();
    wff_log.delete();
    start_cnt = 0; rd_cnt = 0; rd_bad = 0; prs_rst_cnt = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1 TICK = 1'b1;
      @(posedge clk); #1 TICK = 1'b0;
    end
  endtask

  task automatic wait_refresh(input string tag);
    bit seen = 0;
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (BUSY) seen = 1;
      else if (seen) break;
    end
    check(tag, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_start(input int k, input string tag);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (start_cnt >= k) break;
    end
    check(tag, 32'(start_cnt >= k), 32'd1);
  endtask

  function automatic logic [31:0] wff_word();
    if (wff_log.size() != 4) return 32'hDEADBEEF;
    return {wff_log[0], wff_log[1], wff_log[2], wff_log[3]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit got_gnt;
    int n;
    for (int i = 0; i < 7; i++) begin daq_b[i] = 8'(i + 1); trg_b[i] = 8'(i + 1); end
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {23'd0, JTAG_GNT, WFF_WE, PRS_START, RBK_RDENA, PRS_RESET,
                        SIG_VLD, SIG_CHG, TMO_ERR, BUSY}, 32'd0);
    check("rst_bytes", {8'd0, DAQ_SIG, TRG_SIG, WFF_DATA}, 32'd0);
    rst_fifo = 1'b0;

    // Disabled refresh: period 0, then ENA low; counter must stay at 0.
    REFRESH_ENA = 1'b1; REFRESH_PERIOD = 16'd0;
    ticks(5);
    repeat (4) @(negedge clk);
    check("per0_idle", {31'd0, BUSY} | 32'(start_cnt), 32'd0);
    REFRESH_ENA = 1'b0; REFRESH_PERIOD = 16'd3;
    ticks(2);
    REFRESH_ENA = 1'b1;
    ticks(2);
    repeat (4) @(negedge clk);
    check("ena_hold_idle", {31'd0, BUSY} | 32'(start_cnt), 32'd0);

    // First refresh: third enabled tick. XOR of 01..07 is 00.
    clr_logs();
    ticks(1);
    wait_refresh("r1_done");
    check("r1_wff", wff_word(), 32'h7A007C00);
    check("r1_starts", start_cnt, 2);
    check("r1_reads", rd_cnt, 14);
    check("r1_sigs", {16'd0, DAQ_SIG, TRG_SIG}, 32'h0000);
    check("r1_vld_chg", {30'd0, SIG_VLD, SIG_CHG}, 32'd2);

    // Second refresh, DAQ byte 07 -> 06: 00 ^ 07 ^ 06 = 01.
    daq_b[6] = 8'h06;
    clr_logs();
    ticks(3);
    wait_refresh("r2_done");
    check("r2_sigs", {16'd0, DAQ_SIG, TRG_SIG}, 32'h0100);
    check("r2_vld_chg", {30'd0, SIG_VLD, SIG_CHG}, 32'd3);
    check("r2_reads", rd_cnt, 14);

    // JTAG request meets a pending refresh in the same IDLE cycle.
    ticks(2);
    @(posedge clk); #1 TICK = 1'b1;
    @(posedge clk); #1 TICK = 1'b0; JTAG_REQ = 1'b1;
    @(posedge clk); @(negedge clk);
    check("jt_gnt", {30'd0, JTAG_GNT, BUSY}, 32'd3);
    JTAG_WDATA = 8'hA5; JTAG_WE = 1'b1; JTAG_START = 1'b1; JTAG_RDENA = 1'b1;
    #1 check("jt_pass", {21'd0, WFF_DATA, WFF_WE, PRS_START, RBK_RDENA}, {21'd0, 8'hA5, 3'b111});
    JTAG_WE = 1'b0; JTAG_START = 1'b0; JTAG_RDENA = 1'b0;
    #1 check("jt_pass_lo", {29'd0, WFF_WE, PRS_START, RBK_RDENA}, 32'd0);
    clr_logs();
    repeat (3) @(posedge clk);
    #1 JTAG_REQ = 1'b0;
    @(posedge clk); @(negedge clk);
    check("jt_exit_idle", {30'd0, JTAG_GNT, BUSY}, 32'd0);
    @(negedge clk);
    check("jt_then_cmd", {23'd0, WFF_WE, WFF_DATA}, 32'h17A);
    wait_refresh("jt_r_done");
    check("jt_r_reads", rd_cnt, 14);
    check("jt_r_sigs", {16'd0, DAQ_SIG, TRG_SIG}, 32'h0100);

    // JTAG request during R_WAIT waits for the whole refresh; its writes go nowhere.
    done_wait = 30;
    clr_logs();
    ticks(3);
    wait_start(1, "nw_start");
    @(posedge clk); #1 JTAG_REQ = 1'b1; JTAG_WDATA = 8'h55;
    got_gnt = 0;
    for (n = 0; n < 400; n++) begin
      @(posedge clk); #1 JTAG_WE = ~JTAG_WE;
      @(negedge clk);
      if (JTAG_GNT) begin got_gnt = 1; break; end
    end
    check("nw_gnt_seen", 32'(got_gnt), 32'd1);
    check("nw_wff", wff_word(), 32'h7A007C00);
    check("nw_reads", rd_cnt, 14);
    check("nw_vld", 32'(SIG_VLD), 32'd1);
    JTAG_WE = 1'b0; JTAG_REQ = 1'b0;
    repeat (3) @(negedge clk);
    done_wait = 3;

    // Readback FIFO empty on alternate cycles.
    tog = 1;
    clr_logs();
    ticks(3);
    wait_refresh("tg_done");
    check("tg_reads", rd_cnt, 14);
    check("tg_rd_empty", rd_bad, 0);
    check("tg_sigs", {16'd0, DAQ_SIG, TRG_SIG}, 32'h0100);
    tog = 0;

    // Parser never reports done.
    auto_done = 0;
    clr_logs();
    ticks(3);
    wait_start(1, "wd_start");
`ifdef I2C_SCHED_WDOG_EN
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (prs_rst_cnt > 0) break;
    end
    check("wd_latency", rst_cyc - start_cyc, TMO + 1);
    repeat (3) @(negedge clk);
    check("wd_pulse", prs_rst_cnt, 1);
    check("wd_err_idle", {30'd0, TMO_ERR, BUSY}, 32'd2);
    check("wd_sigs", {15'd0, SIG_VLD, DAQ_SIG, TRG_SIG}, 32'h10100);
    clr_logs();
    ticks(3);
`else
    repeat (TMO + 20) @(negedge clk);
    check("nowd_hang", {29'd0, BUSY, PRS_RESET, TMO_ERR}, 32'd4);
    check("nowd_noreset", prs_rst_cnt, 0);
    ticks(3);
`endif

    // Asynchronous reset in the middle of a refresh.
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(BUSY), 32'd1);
    @(posedge clk); #1 rst_fifo = 1'b1;
    #1 check("mid_rst", {6'd0, BUSY, SIG_VLD, SIG_CHG, TMO_ERR, PRS_RESET, WFF_WE,
                         DAQ_SIG, TRG_SIG, 4'd0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_fifo = 1'b0;
    clr_logs();
    repeat (10) @(negedge clk);
    check("post_rst_idle", {31'd0, BUSY} | 32'(start_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
